// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD driver.
package lcd_pkg;

    typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, HOLD, EXEC, IDLE} lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_xfer_t;

    localparam int INIT_LEN = 6;
    // Index 0 is the first byte sent: 0x38 x3, display on, clear, entry mode.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    localparam int BIT_ON   = 31;
    localparam int BIT_BLON = 30;
    localparam int BIT_REQ  = 16;
    localparam int BIT_RS   = 9;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input lcd_xfer_t x);
        return !x.rs && (x.data == 8'h01 || x.data == 8'h02 || x.data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by all timed states; holds at zero.
module lcd_delay_cnt #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            cnt <= RST_VAL;
        else if (i_load)
            cnt <= i_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus sequencer: runs power-on init, then one byte per REQ toggle.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 3,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_ready,
    output logic        o_lcd_busy
);

    localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_SETUP), max_of(T_EN, T_HOLD)),
                                  max_of(T_CMD, T_CLEAR));
    localparam int CW    = $clog2(T_MAX + 1);

    lcd_state_t     state;
    lcd_xfer_t      xfer;
    logic [2:0]     rom_idx;
    logic [2:0]     rom_nxt;
    logic           req_seen;
    logic           ready, busy, en, on, blon;
    logic           req_pend;
    logic           cnt_zero, cnt_load;
    logic [CW-1:0]  cnt_val;
    logic           unused_bits;

    assign req_pend    = i_io_lcd[BIT_REQ] != req_seen;
    assign rom_nxt     = rom_idx + 3'd1;
    assign unused_bits = ^{i_io_lcd[29:17], i_io_lcd[15:10], i_io_lcd[8]};

    // Counter reloads on the same edge as the state change, with the next state's length.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = CW'(T_SETUP - 1);
        unique case (state)
            IDLE:  cnt_load = ready && req_pend;
            SETUP: begin cnt_load = cnt_zero; cnt_val = CW'(T_EN - 1);   end
            EN_HI: begin cnt_load = cnt_zero; cnt_val = CW'(T_HOLD - 1); end
            HOLD: begin
                cnt_load = cnt_zero;
                cnt_val  = is_slow_cmd(xfer) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
            end
            default: cnt_load = cnt_zero;
        endcase
    end

    lcd_delay_cnt #(
        .W       (CW),
        .RST_VAL (CW'(T_PWRUP - 1))
    ) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (cnt_load),
        .i_val   (cnt_val),
        .o_zero  (cnt_zero)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= PWRUP;
            xfer     <= '0;
            rom_idx  <= '0;
            req_seen <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            en       <= 1'b0;
            on       <= 1'b0;
            blon     <= 1'b0;
        end else begin
            on   <= i_io_lcd[BIT_ON];
            blon <= i_io_lcd[BIT_BLON];
            unique case (state)
                PWRUP: begin
                    busy <= 1'b1;
                    if (cnt_zero) begin
                        xfer.rs   <= 1'b0;
                        xfer.data <= INIT_ROM[0];
                        rom_idx   <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: if (cnt_zero) begin
                    en    <= 1'b1;
                    state <= EN_HI;
                end
                EN_HI: if (cnt_zero) begin
                    en    <= 1'b0;
                    state <= HOLD;
                end
                HOLD: if (cnt_zero) state <= EXEC;
                EXEC: if (cnt_zero) begin
                    if (!ready && rom_idx != 3'(INIT_LEN - 1)) begin
                        rom_idx   <= rom_nxt;
                        xfer.data <= INIT_ROM[rom_nxt];
                        state     <= SETUP;
                    end else begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                IDLE: if (ready && req_pend) begin
                    xfer.rs   <= i_io_lcd[BIT_RS];
                    xfer.data <= i_io_lcd[DATA_MSB:DATA_LSB];
                    req_seen  <= i_io_lcd[BIT_REQ];
                    busy      <= 1'b1;
                    state     <= SETUP;
                end
                default: state <= PWRUP;
            endcase
        end
    end

    assign o_lcd_on    = on;
    assign o_lcd_blon  = blon;
    assign o_lcd_en    = en;
    assign o_lcd_rs    = xfer.rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = xfer.data;
    assign o_lcd_ready = ready;
    assign o_lcd_busy  = busy;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboarded bench for lcd_ctrl: EN pulses are checked against a queue of expected bus cycles.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] io  = '0;
    logic        on, blon, en, rs, rw, ready, busy;
    logic [7:0]  data;

    lcd_ctrl #(.T_PWRUP(20), .T_CMD(8), .T_CLEAR(30)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_io_lcd    (io),
        .o_lcd_on    (on),
        .o_lcd_blon  (blon),
        .o_lcd_en    (en),
        .o_lcd_rs    (rs),
        .o_lcd_rw    (rw),
        .o_lcd_data  (data),
        .o_lcd_ready (ready),
        .o_lcd_busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic rs; logic [7:0] data; int gap;} pulse_t;
    typedef struct {logic rs; logic [7:0] data; int busy_n;} vec_t;

    pulse_t exp_q[$];
    vec_t   tv[7];
    int     vec_n = 0, err_n = 0, cyc = 0, pulses = 0;
    logic   par = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vec_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [7:0] d, input int g);
        pulse_t p;
        p.rs = r; p.data = d; p.gap = g;
        exp_q.push_back(p);
    endtask

    // Gap = cycles from EN fall to next EN rise: HOLD + EXEC + SETUP.
    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h38, 13);
        push(1'b0, 8'h38, 13);
        push(1'b0, 8'h0C, 13);
        push(1'b0, 8'h01, 13);
        push(1'b0, 8'h06, 35);
    endtask

    function automatic logic [31:0] mk(input logic p, input logic r, input logic [7:0] d,
                                       input logic [1:0] pw);
        return {pw, 13'b0, p, 6'b0, r, 1'b0, d};
    endfunction

    task automatic wait_ready(input int n0, output int n);
        n = n0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
    endtask

    task automatic do_xfer(input logic r, input logic [7:0] d, output int n);
        par = ~par;
        @(posedge clk); #1;
        io = ($urandom & 32'h3FFE_FD00) | mk(par, r, d, io[31:30]);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
    endtask

    // Bus monitor: measures each EN pulse and checks it against the scoreboard.
    initial begin
        logic       en_prev;
        logic       rise_rs;
        logic [7:0] rise_d;
        int         hi, gap, last_fall;
        pulse_t     e;
        en_prev = 1'b0; hi = 0; gap = 0; last_fall = 0; rise_rs = 1'b0; rise_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                en_prev = 1'b0;
            end else begin
                if (en && !en_prev) begin
                    hi = 1; rise_rs = rs; rise_d = data; gap = cyc - last_fall;
                end else if (en) begin
                    hi++;
                end
                if (!en && en_prev) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        vec_n++; err_n++;
                        $display("FAIL unexpected_pulse: got rs=%0d data=0x%0h expected none",
                                 rise_rs, rise_d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_rs", int'(rise_rs), int'(e.rs));
                        chk("pulse_data", int'(rise_d), int'(e.data));
                        chk("pulse_width", hi, 12);
                        chk("hold_data", int'(data), int'(e.data));
                        chk("hold_rs", int'(rs), int'(e.rs));
                        if (e.gap > 0) chk("pulse_gap", gap, e.gap);
                    end
                    last_fall = cyc;
                end
                en_prev = en;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, p0;
        tv[0] = '{1'b1, 8'h41, 26};
        tv[1] = '{1'b0, 8'h01, 48};
        tv[2] = '{1'b0, 8'h02, 48};
        tv[3] = '{1'b0, 8'h03, 48};
        tv[4] = '{1'b0, 8'h04, 26};
        tv[5] = '{1'b1, 8'h01, 26};
        tv[6] = '{1'b0, 8'hFF, 26};

        // Reset state and power-on init
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", int'({on, blon, en, rs, rw, ready, busy, data}), 0);
        push_init();
        p0  = pulses;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_release", int'(busy), 1);
        chk("ready_after_release", int'(ready), 0);
        wait_ready(1, n);
        chk("init_cycles", n, 192);
        chk("init_busy_clear", int'(busy), 0);
        chk("init_pulses", pulses - p0, 6);
        chk("init_queue_empty", exp_q.size(), 0);

        // Table-driven transfers
        p0 = pulses;
        for (int i = 0; i < 7; i++) begin
            push(tv[i].rs, tv[i].data, 0);
            do_xfer(tv[i].rs, tv[i].data, n);
            chk($sformatf("vec%0d_busy_cycles", i), n, tv[i].busy_n);
            chk($sformatf("vec%0d_rw", i), int'(rw), 0);
            @(posedge clk); #1;
        end
        chk("table_pulses", pulses - p0, 7);

        // Pending toggle served at IDLE with data sampled then
        p0 = pulses;
        push(1'b1, 8'h11, 0);
        push(1'b0, 8'h33, 0);
        par = ~par; io = mk(par, 1'b1, 8'h11, 2'b00);
        repeat (5) @(posedge clk); #1;
        par = ~par; io = mk(par, 1'b1, 8'h22, 2'b00);
        repeat (10) @(posedge clk); #1;
        io = mk(par, 1'b0, 8'h33, 2'b00);
        repeat (80) @(posedge clk); #1;
        chk("pending_pulses", pulses - p0, 2);
        chk("pending_req_seen", int'(dut.req_seen), int'(par));
        chk("pending_busy", int'(busy), 0);

        // Two toggles in one transfer collapse
        p0 = pulses;
        push(1'b1, 8'h44, 0);
        par = ~par; io = mk(par, 1'b1, 8'h44, 2'b00);
        repeat (5) @(posedge clk); #1;
        io = mk(~par, 1'b1, 8'h45, 2'b00);
        repeat (5) @(posedge clk); #1;
        io = mk(par, 1'b1, 8'h46, 2'b00);
        repeat (60) @(posedge clk); #1;
        chk("double_toggle_pulses", pulses - p0, 1);
        chk("double_toggle_req_seen", int'(dut.req_seen), int'(par));

        // Power / backlight follow bits 31:30 without bus activity
        p0 = pulses;
        io = io | 32'hC000_0000;
        @(posedge clk); #1;
        chk("power_on", int'({on, blon}), 3);
        repeat (20) @(posedge clk); #1;
        chk("power_no_en", pulses - p0, 0);
        chk("power_busy", int'(busy), 0);
        io = io & 32'h3FFF_FFFF;
        @(posedge clk); #1;
        chk("power_off", int'({on, blon}), 0);

        // Reset while EN is high, with a toggle during the re-init
        io = io | 32'hC000_0000;
        push(1'b1, 8'h5A, 0);
        par = ~par; io = mk(par, 1'b1, 8'h5A, 2'b11);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (en) break;
        end
        chk("en_before_reset", int'(en), 1);
        rst = 1'b1; #1;
        chk("reset_mid_pulse", int'({on, blon, en, rs, rw, ready, busy, data}), 0);
        exp_q.delete();
        par = 1'b0;
        io  = mk(1'b0, 1'b0, 8'h00, 2'b11);
        repeat (2) @(posedge clk); #1;
        push_init();
        push(1'b1, 8'h55, 0);
        p0  = pulses;
        rst = 1'b0;
        n   = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            n = i;
            if (i == 30) begin
                par = 1'b1;
                io  = mk(1'b1, 1'b1, 8'h55, 2'b11);
            end
            if (ready) break;
        end
        chk("reinit_cycles", n, 192);
        repeat (40) @(posedge clk); #1;
        chk("reinit_pulses", pulses - p0, 7);
        chk("reinit_queue_empty", exp_q.size(), 0);
        chk("reinit_busy", int'(busy), 0);
        chk("reinit_req_seen", int'(dut.req_seen), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
